request_unit: RTL and testbench

- Sequences memory requests between the decode/control stage and the instruction/data memory port of the single-cycle MIPS datapath.
- Takes the decoded per-instruction memory intent (data read, data write, halt) as a one-shot level for the current instruction.
- Turns that intent into held memory request strobes that stay up until ihit/dhit, and generates the PC-advance enable.
- Adds a sticky halt, a hang watchdog and a saturating stall-cycle counter for debug.

---
 rtl/request_unit_pkg.sv | 14 +
 rtl/request_unit_sat_counter.sv | 34 +++
 rtl/request_unit.sv | 137 +++++++++++++
 tb/tb_request_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/request_unit_pkg.sv
// rtl/request_unit_pkg.sv - shared types for the memory request sequencer
package request_unit_pkg;

   typedef enum logic [1:0] {
      REQ_FETCH,
      REQ_DATA,
      REQ_HALTED
   } reqstate_t;

   function automatic logic mem_op(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/request_unit_sat_counter.sv
// rtl/request_unit_sat_counter.sv - up counter that sticks at all-ones, clear has priority
module request_unit_sat_counter #(
   parameter int W = 4
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - fetch/data request sequencer with sticky halt, watchdog and stall counter
module request_unit #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             cu_dREN,
   input  logic             cu_dWEN,
   input  logic             cu_Halt,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pcEN,
   output logic             halt,
   output logic             timeout,
   output logic [CNT_W-1:0] stall_cnt
);

   import request_unit_pkg::*;

   localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   reqstate_t   state_q, state_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        halt_q, halt_d;
   logic        timeout_q, timeout_d;
   logic        pc_en_raw;
   logic        hit;
   logic        wait_inc;
   logic        wait_clr;
   logic        stall_inc;
   logic [WAIT_W-1:0] wait_cnt;

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      halt_d    = halt_q;
      timeout_d = timeout_q;
      pc_en_raw = 1'b0;
      hit       = 1'b0;
      wait_inc  = 1'b0;
      case (state_q)
         REQ_FETCH: begin
            hit = ihit;
            if (ihit) begin
               if (cu_Halt) begin
                  state_d = REQ_HALTED;
                  halt_d  = 1'b1;
               end else if (mem_op(cu_dREN, cu_dWEN)) begin
                  // Read wins when decode flags both directions.
                  state_d = REQ_DATA;
                  rd_d    = cu_dREN;
                  wr_d    = ~cu_dREN;
               end else begin
                  pc_en_raw = 1'b1;
               end
            end else begin
               wait_inc = 1'b1;
            end
         end
         REQ_DATA: begin
            hit = dhit;
            if (dhit) begin
               pc_en_raw = 1'b1;
               state_d   = REQ_FETCH;
               rd_d      = 1'b0;
               wr_d      = 1'b0;
            end else begin
               wait_inc = 1'b1;
            end
         end
         REQ_HALTED: begin
         end
         default: begin
            state_d = REQ_FETCH;
         end
      endcase

      // A hit in the last allowed cycle never reaches here because wait_inc is low.
      if (wait_inc && (wait_cnt == WAIT_LAST)) begin
         state_d   = REQ_HALTED;
         halt_d    = 1'b1;
         timeout_d = 1'b1;
         rd_d      = 1'b0;
         wr_d      = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= REQ_FETCH;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         halt_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         halt_q    <= halt_d;
         timeout_q <= timeout_d;
      end
   end

   assign wait_clr  = hit | (state_d != state_q);
   assign stall_inc = (state_q != REQ_HALTED) & ~pcEN;

   request_unit_sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (wait_inc),
      .clr (wait_clr),
      .cnt (wait_cnt)
   );

   request_unit_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (stall_inc),
      .clr (1'b0),
      .cnt (stall_cnt)
   );

   assign pcEN    = pc_en_raw & ~RST;
   assign imemREN = (state_q == REQ_FETCH);
   assign dmemREN = (state_q == REQ_DATA) & rd_q;
   assign dmemWEN = (state_q == REQ_DATA) & wr_q;
   assign halt    = halt_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - directed and randomized checks of request_unit against a behavioural model
module tb_request_unit;

   localparam int TB_TIMEOUT = 8;
   localparam int TB_CNT_W   = 3;
   localparam int STALL_MAX  = (1 << TB_CNT_W) - 1;

   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic                ihit = 1'b0;
   logic                dhit = 1'b0;
   logic                cu_dREN = 1'b0;
   logic                cu_dWEN = 1'b0;
   logic                cu_Halt = 1'b0;
   logic                imemREN;
   logic                dmemREN;
   logic                dmemWEN;
   logic                pcEN;
   logic                halt;
   logic                timeout;
   logic [TB_CNT_W-1:0] stall_cnt;

   request_unit #(
      .TIMEOUT_CYCLES (TB_TIMEOUT),
      .CNT_W          (TB_CNT_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ihit      (ihit),
      .dhit      (dhit),
      .cu_dREN   (cu_dREN),
      .cu_dWEN   (cu_dWEN),
      .cu_Halt   (cu_Halt),
      .imemREN   (imemREN),
      .dmemREN   (dmemREN),
      .dmemWEN   (dmemWEN),
      .pcEN      (pcEN),
      .halt      (halt),
      .timeout   (timeout),
      .stall_cnt (stall_cnt)
   );

   always #5 CLK = ~CLK;

   // Model: an outstanding data op (busy, direction), halted/timed-out flags, cycles waited.
   bit m_busy = 0, m_rd = 0, m_wr = 0, m_halt = 0, m_to = 0;
   int m_wait = 0, m_stall = 0;
   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   function automatic bit exp_pc();
      if (RST || m_halt) return 1'b0;
      if (m_busy) return dhit;
      return ihit && !cu_Halt && !cu_dREN && !cu_dWEN;
   endfunction

   task automatic check_all();
      check("imemREN", imemREN, !m_halt && !m_busy);
      check("dmemREN", dmemREN, m_busy && m_rd);
      check("dmemWEN", dmemWEN, m_busy && m_wr);
      check("pcEN", pcEN, exp_pc());
      check("halt", halt, m_halt);
      check("timeout", timeout, m_to);
      check("stall_cnt", stall_cnt, m_stall);
   endtask

   task automatic apply(input logic r, input logic i, input logic d,
                        input logic lr, input logic lw, input logic lh);
      @(negedge CLK);
      RST = r; ihit = i; dhit = d; cu_dREN = lr; cu_dWEN = lw; cu_Halt = lh;
      #1;
      check_all();
   endtask

   task automatic advance();
      bit pc;
      pc = exp_pc();
      if (RST) begin
         m_busy = 0; m_rd = 0; m_wr = 0; m_halt = 0; m_to = 0; m_wait = 0; m_stall = 0;
      end else if (!m_halt) begin
         if (!pc && m_stall < STALL_MAX) m_stall++;
         if (m_busy ? dhit : ihit) begin
            m_wait = 0;
            if (m_busy) begin
               m_busy = 0; m_rd = 0; m_wr = 0;
            end else if (cu_Halt) begin
               m_halt = 1;
            end else if (cu_dREN || cu_dWEN) begin
               m_busy = 1; m_rd = cu_dREN; m_wr = !cu_dREN;
            end
         end else if (m_wait == TB_TIMEOUT - 1) begin
            m_halt = 1; m_to = 1; m_busy = 0; m_rd = 0; m_wr = 0; m_wait = 0;
         end else begin
            m_wait++;
         end
      end
      @(posedge CLK);
   endtask

   task automatic cyc(input logic r, input logic i, input logic d,
                      input logic lr, input logic lw, input logic lh);
      apply(r, i, d, lr, lw, lh);
      advance();
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset and ALU op
      do_reset();
      apply(0, 0, 0, 0, 0, 0);
      check("rst_imem", imemREN, 1);
      check("rst_stall", stall_cnt, 0);
      advance();
      apply(0, 1, 0, 0, 0, 0);
      check("alu_pcen", pcEN, 1);
      advance();
      apply(0, 0, 0, 0, 0, 0);
      check("alu_stall", stall_cnt, 1);
      check("alu_imem", imemREN, 1);
      advance();

      // Load, dhit 3 cycles after DATA entry
      do_reset();
      cyc(0, 0, 0, 0, 0, 0);
      apply(0, 1, 0, 1, 0, 0);
      check("ld_issue_pcen", pcEN, 0);
      advance();
      for (int k = 0; k < 4; k++) begin
         apply(0, 1, (k == 3), 0, 0, 0);
         check("ld_dren", dmemREN, 1);
         check("ld_pcen", pcEN, (k == 3));
         advance();
      end
      apply(0, 0, 0, 0, 0, 0);
      check("ld_back_imem", imemREN, 1);
      check("ld_stall", stall_cnt, 5);
      advance();

      // Store, then read priority
      cyc(0, 1, 0, 0, 1, 0);
      apply(0, 0, 1, 0, 0, 0);
      check("st_dwen", dmemWEN, 1);
      check("st_dren", dmemREN, 0);
      advance();
      cyc(0, 1, 0, 1, 1, 0);
      apply(0, 0, 1, 0, 0, 0);
      check("prio_dren", dmemREN, 1);
      check("prio_dwen", dmemWEN, 0);
      advance();

      // Halt beats load
      cyc(0, 1, 0, 1, 0, 1);
      for (int k = 0; k < 10; k++) begin
         apply(0, k[0], !k[0], 0, 0, 0);
         check("halt_sticky", halt, 1);
         check("halt_no_dren", dmemREN, 0);
         advance();
      end
      do_reset();
      apply(0, 0, 0, 0, 0, 0);
      check("halt_cleared", halt, 0);
      check("halt_rst_imem", imemREN, 1);
      advance();

      // Watchdog trips 8 cycles after DATA entry
      cyc(0, 1, 0, 1, 0, 0);
      for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0);
      check("wd_timeout", timeout, 1);
      check("wd_halt", halt, 1);
      advance();

      // dhit on the last allowed cycle wins
      do_reset();
      cyc(0, 1, 0, 1, 0, 0);
      for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, 0, 0);
      apply(0, 0, 1, 0, 0, 0);
      check("wd_late_pcen", pcEN, 1);
      advance();
      apply(0, 0, 0, 0, 0, 0);
      check("wd_no_trip", timeout, 0);
      advance();

      // Stall counter saturation
      do_reset();
      for (int k = 0; k < 20; k++) begin
         cyc(0, 1, 0, 1, 0, 0);
         cyc(0, 0, 1, 0, 0, 0);
      end
      apply(0, 0, 0, 0, 0, 0);
      check("stall_sat", stall_cnt, 7);
      advance();

      // Reset mid-DATA drops the request
      cyc(0, 1, 0, 0, 1, 0);
      apply(1, 0, 1, 0, 0, 0);
      check("rst_mid_pcen", pcEN, 0);
      advance();
      apply(0, 0, 0, 0, 0, 0);
      check("rst_mid_dwen", dmemWEN, 0);
      check("rst_mid_imem", imemREN, 1);
      advance();

      // dhit together with ihit in FETCH is ignored
      cyc(0, 1, 1, 1, 0, 0);
      apply(0, 0, 0, 0, 0, 0);
      check("fetch_dhit_ignored", dmemREN, 1);
      advance();
      cyc(0, 0, 1, 0, 0, 0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 49) == 0),
             $urandom_range(0, 1),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 29) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
